cassette_stream: RTL and testbench

CASSETTE_STREAM -- requirements
Module: cassette_stream

---
 rtl/cassette_stream.sv | 237 +++++++++++++++++++++++
 tb/tb_cassette_stream.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cassette_stream.sv
// -----------------------------------------------------------------------------
// cassette_stream
//
// Replays a byte-addressed tape image as a cassette-style audio bit stream.
// Each byte is fetched once from an external memory, framed and shifted out
// LSB first. Every bit is encoded as a fixed-length burst of square wave.
//
// Header lead-in bytes are replayed LEAD_MULT times each. Lead-in and sync
// frames have no stop bits. Data frames carry two stop bits.
//
// Bit encoding:
//   '0' : one period of HALF0 clocks high, then HALF0 clocks low.
//   '1' : two periods of HALF1 clocks high, then HALF1 clocks low.
//
// Ports:
//   clk        single clock; all logic runs on its rising edge
//   reset      asynchronous, active-high reset
//   play       level input; a rising edge starts playback, a falling edge stops it
//   rewind     a rising edge returns the tape to address 0
//   tape_len   number of valid image bytes (0 = empty tape)
//   mem_addr   byte address being read
//   mem_rd     read request (level), held until mem_ready
//   mem_data   read data, valid while mem_ready is high
//   mem_ready  one-cycle read-complete strobe
//   data       registered cassette audio bit stream
//   eot        end of tape reached
//   status     current FSM state code
// -----------------------------------------------------------------------------
module cassette_stream #(
  parameter int ADDR_W    = 21,
  parameter int LEAD_LEN  = 16,
  parameter int LEAD_MULT = 25,
  parameter int HDR0_ADDR = 'h00,
  parameter int HDR1_ADDR = 'h23,
  parameter int HALF0     = 1864,
  parameter int HALF1     = 932
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              rewind,
  input  logic [ADDR_W-1:0] tape_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  input  logic              mem_ready,
  output logic              data,
  output logic              eot,
  output logic [2:0]        status
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_EOT   = 3'd5;

  localparam int HMAX  = (HALF0 > HALF1) ? HALF0 : HALF1;
  localparam int CNT_W = $clog2(HMAX + 1);
  localparam int REP_W = $clog2(LEAD_MULT + 1);

  localparam logic [CNT_W-1:0]  H0_LAST  = CNT_W'(HALF0 - 1);
  localparam logic [CNT_W-1:0]  H1_LAST  = CNT_W'(HALF1 - 1);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(LEAD_MULT - 1);
  localparam logic [ADDR_W-1:0] HDR0_A   = ADDR_W'(HDR0_ADDR);
  localparam logic [ADDR_W-1:0] HDR1_A   = ADDR_W'(HDR1_ADDR);
  localparam logic [ADDR_W-1:0] LEAD_A   = ADDR_W'(LEAD_LEN);

  logic [2:0]        state;
  logic              play_d;
  logic              rewind_d;
  logic              play_armed;
  logic [7:0]        byte_q;
  logic [10:0]       frame;
  logic [3:0]        last_bit;
  logic [3:0]        bit_idx;
  logic [1:0]        half_idx;
  logic [CNT_W-1:0]  half_cnt;
  logic [REP_W-1:0]  rep_cnt;

  // play_armed stays low after reset until play has been seen low once.
  // This prevents a play level held high through reset from looking like a
  // fresh rising edge.
  logic play_rise, play_fall, rewind_rise;
  assign play_rise   = play & ~play_d & play_armed;
  assign play_fall   = ~play & play_d;
  assign rewind_rise = rewind & ~rewind_d;

  // Region classification uses an offset from each header base. This keeps
  // the window test a single unsigned compare with modulo address arithmetic.
  logic [ADDR_W-1:0] off0, off1, addr_inc;
  logic              is_lead, is_sync, is_data;
  assign off0     = mem_addr - HDR0_A;
  assign off1     = mem_addr - HDR1_A;
  assign is_lead  = (off0 < LEAD_A) || (off1 < LEAD_A);
  assign is_sync  = (off0 == LEAD_A) || (off1 == LEAD_A);
  assign is_data  = ~is_lead & ~is_sync;
  assign addr_inc = mem_addr + ADDR_W'(1);

  // frame[0] is the bit currently on air. It selects the half-period length
  // and how many half-periods make up the bit (2 for '0', 4 for '1').
  logic [CNT_W-1:0] half_last_cnt;
  logic [1:0]       half_last_idx;
  logic             half_end;
  assign half_last_cnt = frame[0] ? H1_LAST : H0_LAST;
  assign half_last_idx = frame[0] ? 2'd3 : 2'd1;
  assign half_end      = (half_cnt == half_last_cnt);

  assign status = state;

  // NOTE: every flop, including the edge-detect copies and the datapath
  // registers, is cleared by the async reset, so no X ever reaches an output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      play_d     <= 1'b0;
      rewind_d   <= 1'b0;
      play_armed <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      data       <= 1'b0;
      eot        <= 1'b0;
      byte_q     <= '0;
      frame      <= '0;
      last_bit   <= '0;
      bit_idx    <= '0;
      half_idx   <= '0;
      half_cnt   <= '0;
      rep_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // reads the pre-edge values of state, counters and edge copies.
      play_d   <= play;
      rewind_d <= rewind;
      if (!play) play_armed <= 1'b1;

      if (rewind_rise) begin
        mem_addr <= '0;
        mem_rd   <= 1'b0;
        eot      <= 1'b0;
        data     <= 1'b0;
        rep_cnt  <= '0;
        state    <= S_IDLE;
      end else if (play_fall) begin
        // Abort: the address is kept so playback resumes at the same byte.
        mem_rd  <= 1'b0;
        data    <= 1'b0;
        eot     <= 1'b0;
        rep_cnt <= '0;
        state   <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (play_rise) begin
              if (mem_addr >= tape_len) begin
                eot   <= 1'b1;
                state <= S_EOT;
              end else begin
                mem_rd <= 1'b1;
                state  <= S_FETCH;
              end
            end
          end

          S_FETCH: begin
            if (mem_ready) begin
              byte_q <= mem_data;
              mem_rd <= 1'b0;
              state  <= S_LOAD;
            end
          end

          S_LOAD: begin
            frame    <= {2'b11, byte_q, 1'b0};
            last_bit <= is_data ? 4'd10 : 4'd8;
            bit_idx  <= '0;
            half_idx <= '0;
            half_cnt <= '0;
            data     <= 1'b1;  // every bit starts with a high half-period
            state    <= S_SHIFT;
          end

          S_SHIFT: begin
            if (!half_end) begin
              half_cnt <= half_cnt + CNT_W'(1);
            end else begin
              half_cnt <= '0;
              if (half_idx != half_last_idx) begin
                half_idx <= half_idx + 2'd1;
                // Even half-periods are high, odd ones low.
                data     <= half_idx[0];
              end else begin
                half_idx <= '0;
                if (bit_idx == last_bit) begin
                  data  <= 1'b0;
                  state <= S_NEXT;
                end else begin
                  bit_idx <= bit_idx + 4'd1;
                  frame   <= {1'b0, frame[10:1]};
                  data    <= 1'b1;
                end
              end
            end
          end

          S_NEXT: begin
            if (is_lead && (rep_cnt < REP_LAST)) begin
              // Replay the captured byte without another memory read.
              rep_cnt <= rep_cnt + REP_W'(1);
              state   <= S_LOAD;
            end else begin
              rep_cnt  <= '0;
              mem_addr <= addr_inc;
              if (addr_inc >= tape_len) begin
                eot   <= 1'b1;
                state <= S_EOT;
              end else begin
                mem_rd <= 1'b1;
                state  <= S_FETCH;
              end
            end
          end

          S_EOT: begin
            eot    <= 1'b1;
            data   <= 1'b0;
            mem_rd <= 1'b0;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cassette_stream.sv
// -----------------------------------------------------------------------------
// tb_cassette_stream
//
// Directed self-checking bench for cassette_stream. It uses small parameters:
//   LEAD_LEN=2, LEAD_MULT=3, HDR0_ADDR=0, HDR1_ADDR=8, HALF0=4, HALF1=2
// With these values every bit lasts 8 clocks.
//
// A memory responder process answers mem_rd after one cycle while mem_auto
// is set. Otherwise the scenario drives mem_ready itself.
// -----------------------------------------------------------------------------
module tb_cassette_stream;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              play;
  logic              rewind;
  logic [ADDR_W-1:0] tape_len;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic              mem_ready;
  logic              data;
  logic              eot;
  logic [2:0]        status;

  logic [7:0] mem [0:255];
  logic       mem_auto;
  int         rd_count;
  int         rd_cycles;
  logic [7:0] rd_last_addr;
  logic       rd_prev;

  int pass_cnt  = 0;
  int total_cnt = 0;

  cassette_stream #(
    .ADDR_W(ADDR_W), .LEAD_LEN(2), .LEAD_MULT(3),
    .HDR0_ADDR(0), .HDR1_ADDR(8), .HALF0(4), .HALF1(2)
  ) dut (
    .clk(clk), .reset(reset), .play(play), .rewind(rewind),
    .tape_len(tape_len), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .mem_ready(mem_ready), .data(data),
    .eot(eot), .status(status)
  );

  always #5 clk = ~clk;

  // Memory responder and read monitor. It runs just after each rising edge,
  // away from the main process, which works on falling edges.
  initial begin
    rd_prev = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_auto) begin
        mem_ready = mem_rd;
        mem_data  = mem[mem_addr];
      end
      if (mem_rd && !rd_prev) begin
        rd_count++;
        rd_last_addr = mem_addr;
      end
      if (mem_rd) rd_cycles++;
      rd_prev = mem_rd;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_reads();
    rd_count  = 0;
    rd_cycles = 0;
  endtask

  // Expected waveform for a frame: 8 clocks per bit.
  function automatic logic [127:0] wave_of(input logic [10:0] bits, input int nbits);
    logic [127:0] w;
    int p;
    w = '0;
    p = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < 8; c++) begin
        if (bits[b]) w[p] = ((c % 4) < 2);
        else         w[p] = (c < 4);
        p++;
      end
    end
    return w;
  endfunction

  // Waits (bounded) for SHIFT and records data on every SHIFT clock.
  // gap = falling edges waited before SHIFT; len = SHIFT clocks observed.
  task automatic capture_frame(output logic [127:0] w, output int len, output int gap);
    w   = '0;
    len = 0;
    gap = 0;
    while (status !== 3'd3 && gap < 64) begin
      step();
      gap++;
    end
    while (status === 3'd3 && len < 128) begin
      w[len] = data;
      len++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; play = 1'b0; rewind = 1'b0; tape_len = '0;
    step(); step();
    total_cnt++; if (status !== 3'd0) $display("FAIL reset_status: got %0d want 0", status); else pass_cnt++;
    total_cnt++; if (mem_addr !== 8'd0) $display("FAIL reset_addr: got %0d want 0", mem_addr); else pass_cnt++;
    total_cnt++; if ({mem_rd, data, eot} !== 3'b000) $display("FAIL reset_outs: got %b want 000", {mem_rd, data, eot}); else pass_cnt++;
    // Release reset with play already high: no playback may start.
    play = 1'b1;
    step();
    reset = 1'b0;
    clear_reads();
    repeat (5) step();
    total_cnt++; if (status !== 3'd0) $display("FAIL reset_play_held_status: got %0d want 0", status); else pass_cnt++;
    total_cnt++; if (rd_count !== 0) $display("FAIL reset_play_held_reads: got %0d want 0", rd_count); else pass_cnt++;
    play = 1'b0;
    step();
  endtask

  task automatic test_lead_sync();
    logic [127:0] w;
    int len, gap;
    tape_len = 8'd3;
    mem[0] = 8'h55; mem[1] = 8'h0F; mem[2] = 8'h96;
    clear_reads();
    play = 1'b1;
    // Lead-in byte 0, first replay.
    capture_frame(w, len, gap);
    total_cnt++; if (len !== 72) $display("FAIL lead_len: got %0d want 72", len); else pass_cnt++;
    total_cnt++; if (w !== wave_of(11'b000_1010_1010, 9)) $display("FAIL lead_wave: got %h want %h", w, wave_of(11'b000_1010_1010, 9)); else pass_cnt++;
    total_cnt++; if (status !== 3'd4) $display("FAIL lead_next_state: got %0d want 4", status); else pass_cnt++;
    // Second and third replays follow via NEXT and LOAD only.
    capture_frame(w, len, gap);
    total_cnt++; if (gap !== 2 || len !== 72) $display("FAIL lead_rep2: gap %0d len %0d want 2/72", gap, len); else pass_cnt++;
    capture_frame(w, len, gap);
    total_cnt++; if (gap !== 2 || w !== wave_of(11'b000_1010_1010, 9)) $display("FAIL lead_rep3: gap %0d wave %h", gap, w); else pass_cnt++;
    total_cnt++; if (rd_count !== 1 || rd_last_addr !== 8'd0) $display("FAIL lead_single_read: reads %0d addr %0d want 1/0", rd_count, rd_last_addr); else pass_cnt++;
    // Lead-in byte 1 needs a new fetch.
    capture_frame(w, len, gap);
    total_cnt++; if (gap !== 3 || w !== wave_of(11'b000_0001_1110, 9)) $display("FAIL lead1_frame: gap %0d wave %h want gap 3", gap, w); else pass_cnt++;
    total_cnt++; if (rd_count !== 2 || rd_last_addr !== 8'd1) $display("FAIL lead1_read: reads %0d addr %0d want 2/1", rd_count, rd_last_addr); else pass_cnt++;
    capture_frame(w, len, gap);
    capture_frame(w, len, gap);
    // Sync byte: sent once, with no stop bits.
    capture_frame(w, len, gap);
    total_cnt++; if (len !== 72) $display("FAIL sync_len: got %0d want 72", len); else pass_cnt++;
    total_cnt++; if (w !== wave_of(11'b001_0010_1100, 9)) $display("FAIL sync_wave: got %h want %h", w, wave_of(11'b001_0010_1100, 9)); else pass_cnt++;
    total_cnt++; if (rd_count !== 3) $display("FAIL sync_reads: got %0d want 3", rd_count); else pass_cnt++;
    step();
    total_cnt++; if (status !== 3'd5 || eot !== 1'b1) $display("FAIL lead_eot: status %0d eot %b want 5/1", status, eot); else pass_cnt++;
    total_cnt++; if (mem_addr !== 8'd3 || data !== 1'b0 || mem_rd !== 1'b0) $display("FAIL lead_eot_outs: addr %0d data %b rd %b want 3/0/0", mem_addr, data, mem_rd); else pass_cnt++;
  endtask

  task automatic test_data_byte();
    logic [127:0] w;
    int len, gap;
    play = 1'b0;
    step();
    total_cnt++; if (status !== 3'd0 || eot !== 1'b0 || mem_addr !== 8'd3) $display("FAIL stop_from_eot: status %0d eot %b addr %0d want 0/0/3", status, eot, mem_addr); else pass_cnt++;
    tape_len = 8'd4;
    mem[3] = 8'hA5;
    clear_reads();
    play = 1'b1;
    capture_frame(w, len, gap);
    total_cnt++; if (len !== 88) $display("FAIL data_len: got %0d want 88", len); else pass_cnt++;
    // Bit values on air: 0,1,0,1,0,0,1,0,1,1,1
    total_cnt++; if (w !== wave_of(11'b111_0100_1010, 11)) $display("FAIL data_wave: got %h want %h", w, wave_of(11'b111_0100_1010, 11)); else pass_cnt++;
    total_cnt++; if (rd_count !== 1 || rd_cycles !== 1 || rd_last_addr !== 8'd3) $display("FAIL data_read: reads %0d cycles %0d addr %0d want 1/1/3", rd_count, rd_cycles, rd_last_addr); else pass_cnt++;
    step();
    total_cnt++; if (status !== 3'd5 || eot !== 1'b1 || mem_addr !== 8'd4) $display("FAIL data_eot: status %0d eot %b addr %0d want 5/1/4", status, eot, mem_addr); else pass_cnt++;
  endtask

  task automatic test_edge_cases();
    // Rewind and play falling in the same cycle: rewind wins.
    rewind = 1'b1;
    play   = 1'b0;
    step();
    rewind = 1'b0;
    total_cnt++; if (mem_addr !== 8'd0 || status !== 3'd0 || eot !== 1'b0) $display("FAIL rewind_fall: addr %0d status %0d eot %b want 0/0/0", mem_addr, status, eot); else pass_cnt++;
    // Empty tape: straight to EOT with no read.
    tape_len = 8'd0;
    clear_reads();
    play = 1'b1;
    step();
    total_cnt++; if (status !== 3'd5 || eot !== 1'b1) $display("FAIL empty_eot: status %0d eot %b want 5/1", status, eot); else pass_cnt++;
    repeat (3) step();
    total_cnt++; if (rd_count !== 0 || mem_rd !== 1'b0) $display("FAIL empty_reads: reads %0d rd %b want 0/0", rd_count, mem_rd); else pass_cnt++;
    play = 1'b0;
    step();
    total_cnt++; if (status !== 3'd0 || eot !== 1'b0) $display("FAIL empty_stop: status %0d eot %b want 0/0", status, eot); else pass_cnt++;
  endtask

  task automatic test_abort();
    int n;
    tape_len = 8'd20;
    mem[0] = 8'h00;
    mem[1] = 8'h00;
    mem_auto = 1'b1;
    play = 1'b1;
    n = 0;
    while (!(status === 3'd1 && mem_addr === 8'd1) && n < 400) begin
      step();
      n++;
    end
    // Take over the memory before the responder's strobe is sampled.
    mem_auto  = 1'b0;
    mem_ready = 1'b0;
    step();
    total_cnt++; if (status !== 3'd1 || mem_rd !== 1'b1 || mem_addr !== 8'd1) $display("FAIL fetch_hold: status %0d rd %b addr %0d want 1/1/1", status, mem_rd, mem_addr); else pass_cnt++;
    play = 1'b0;
    step();
    total_cnt++; if (mem_rd !== 1'b0 || status !== 3'd0 || mem_addr !== 8'd1) $display("FAIL abort: rd %b status %0d addr %0d want 0/0/1", mem_rd, status, mem_addr); else pass_cnt++;
    mem_data  = 8'hFF;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    repeat (3) step();
    total_cnt++; if (status !== 3'd0 || mem_rd !== 1'b0 || data !== 1'b0 || mem_addr !== 8'd1) $display("FAIL late_strobe: status %0d rd %b data %b addr %0d want 0/0/0/1", status, mem_rd, data, mem_addr); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int n;
    mem_auto = 1'b1;
    play = 1'b1;
    n = 0;
    while (status !== 3'd3 && n < 20) begin
      step();
      n++;
    end
    total_cnt++; if (status !== 3'd3 || data !== 1'b1 || mem_addr !== 8'd1) $display("FAIL pre_reset: status %0d data %b addr %0d want 3/1/1", status, data, mem_addr); else pass_cnt++;
    #2;
    reset = 1'b1;
    #1;
    total_cnt++; if (status !== 3'd0 || mem_addr !== 8'd0) $display("FAIL async_reset_state: status %0d addr %0d want 0/0", status, mem_addr); else pass_cnt++;
    total_cnt++; if ({mem_rd, data, eot} !== 3'b000) $display("FAIL async_reset_outs: got %b want 000", {mem_rd, data, eot}); else pass_cnt++;
    step();
    reset = 1'b0;
    clear_reads();
    repeat (4) step();
    total_cnt++; if (status !== 3'd0 || rd_count !== 0) $display("FAIL post_reset_held: status %0d reads %0d want 0/0", status, rd_count); else pass_cnt++;
    play = 1'b0;
    step();
    play = 1'b1;
    step();
    total_cnt++; if (status !== 3'd1 || mem_rd !== 1'b1) $display("FAIL post_reset_restart: status %0d rd %b want 1/1", status, mem_rd); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem_auto  = 1'b1;
    mem_ready = 1'b0;
    mem_data  = 8'h00;
    rd_count  = 0;
    rd_cycles = 0;
    rd_last_addr = 8'h00;
    test_reset();
    test_lead_sync();
    test_data_byte();
    test_edge_cases();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
